// File: rtl/axi2apb_pkg.sv
// Shared types and default widths for the AXI-to-APB bridge control path.
package axi2apb_pkg;

    localparam int unsigned ADDR_BITS_DEF      = 24;
    localparam int unsigned ID_BITS_DEF        = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
    localparam int unsigned TO_BITS_DEF        = 8;
    localparam int unsigned DATA_BITS          = 32;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        CAPTURE,
        RESP
    } state_e;

endpackage

// File: rtl/axi2apb_timeout.sv
// ACCESS-phase hang detector: saturating wait counter with a combinational expire flag.
module axi2apb_timeout #(
    parameter int unsigned TO_BITS        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam logic             TO_ON = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [TO_BITS-1:0] LIMIT =
        TO_BITS'((TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);
    localparam logic [TO_BITS-1:0] SAT = '1;

    logic [TO_BITS-1:0] cnt;

    // Saturates rather than wrapping so a disabled or oversized limit can never alias.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != SAT)) begin
            cnt <= cnt + TO_BITS'(1);
        end
    end

    assign expire_c = TO_ON && enable && (cnt == LIMIT);

endmodule

// File: rtl/axi2apb_ctrl.sv
// APB master phase sequencer: one command at a time through SETUP/ACCESS,
// captures the mux's registered response and hands one response back upstream.
module axi2apb_ctrl
    import axi2apb_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = ADDR_BITS_DEF,
    parameter int unsigned ID_BITS        = ID_BITS_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned TO_BITS        = TO_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic                 cmd_read,
    input  logic [ID_BITS-1:0]   cmd_id,
    input  logic [DATA_BITS-1:0] cmd_wdata,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [ADDR_BITS-1:0] paddr,
    output logic [DATA_BITS-1:0] pwdata,
    input  logic                 pready,
    input  logic                 pslverr,
    input  logic [DATA_BITS-1:0] prdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_read,
    output logic [ID_BITS-1:0]   rsp_id,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 timeout_evt
);

    state_e state_q;
    state_e state_d;
    logic   accept_c;
    logic   abort_c;
    logic   expire_c;

    axi2apb_timeout #(
        .TO_BITS        (TO_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (state_q == SETUP),
        .enable   ((state_q == ACCESS) && !pready),
        .expire_c (expire_c)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // expire_c is already gated by !pready, so a same-cycle pready completes normally.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        abort_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept_c = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_d = CAPTURE;
                end else if (expire_c) begin
                    abort_c = 1'b1;
                    state_d = RESP;
                end
            end
            CAPTURE: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_ready   <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_read    <= 1'b0;
            rsp_id      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            cmd_ready   <= (state_d == IDLE);
            psel        <= (state_d == SETUP) || (state_d == ACCESS);
            penable     <= (state_d == ACCESS);
            rsp_valid   <= (state_d == RESP);
            timeout_evt <= abort_c;
            if (accept_c) begin
                paddr    <= cmd_addr;
                pwrite   <= ~cmd_read;
                pwdata   <= cmd_wdata;
                rsp_id   <= cmd_id;
                rsp_read <= cmd_read;
            end
            // The mux clears prdata/pslverr a cycle after psel falls, so sample them here.
            if (state_q == CAPTURE) begin
                rsp_err   <= pslverr;
                rsp_rdata <= rsp_read ? prdata : '0;
            end
            if (abort_c) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axi2apb_ctrl.sv
// Directed bench for axi2apb_ctrl with a small APB slave model and a response scoreboard.
module tb_axi2apb_ctrl;

    localparam int unsigned AW = 24;
    localparam int unsigned IW = 4;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_read;
    logic [IW-1:0] cmd_id;
    logic [31:0]   cmd_wdata;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic          pready;
    logic          pslverr;
    logic [31:0]   prdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_read;
    logic [IW-1:0] rsp_id;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          timeout_evt;

    always #5 clk = ~clk;

    axi2apb_ctrl #(
        .ADDR_BITS      (AW),
        .ID_BITS        (IW),
        .TIMEOUT_CYCLES (TO),
        .TO_BITS        (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_read    (cmd_read),
        .cmd_id      (cmd_id),
        .cmd_wdata   (cmd_wdata),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_read    (rsp_read),
        .rsp_id      (rsp_id),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .timeout_evt (timeout_evt)
    );

    // Slave model standing in for axi2apb_mux: combinational pready, registered prdata/pslverr.
    int          cfg_wait  = 0;
    logic        cfg_stuck = 1'b0;
    logic        cfg_err   = 1'b0;
    logic [31:0] cfg_rdata = '0;
    int          s_wait    = 0;

    assign pready = psel && penable && !cfg_stuck && (s_wait >= cfg_wait);

    always @(posedge clk) begin
        if (psel && penable && !pready) s_wait <= s_wait + 1;
        else if (!penable)              s_wait <= 0;
        if (psel && penable && pready) begin
            prdata  <= cfg_rdata;
            pslverr <= cfg_err;
        end else begin
            prdata  <= '0;
            pslverr <= 1'b0;
        end
    end

    // Running totals of psel/penable/timeout_evt cycles; per-command deltas are checked.
    int psel_cnt = 0;
    int pen_cnt  = 0;
    int tevt_cnt = 0;

    always @(posedge clk) begin
        if (psel)        psel_cnt <= psel_cnt + 1;
        if (penable)     pen_cnt  <= pen_cnt + 1;
        if (timeout_evt) tevt_cnt <= tevt_cnt + 1;
    end

    typedef struct {
        logic          rd;
        logic [IW-1:0] id;
        logic [31:0]   rdata;
        logic          err;
        logic          to;
        int            acc;
        int            p0;
        int            e0;
        int            t0;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command and push its expected response; call at a negedge.
    task automatic arm(input logic [AW-1:0] a, input logic rd, input logic [IW-1:0] id,
                       input logic [31:0] wd, input int wt, input logic [31:0] sd,
                       input logic se, input logic stuck);
        exp_t e;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_read  = rd;
        cmd_id    = id;
        cmd_wdata = wd;
        cfg_wait  = wt;
        cfg_rdata = sd;
        cfg_err   = se;
        cfg_stuck = stuck;
        e.rd    = rd;
        e.id    = id;
        e.to    = stuck;
        e.err   = se | stuck;
        e.rdata = (rd && !stuck) ? sd : 32'h0;
        e.acc   = stuck ? int'(TO) : wt + 1;
        e.p0    = psel_cnt;
        e.e0    = pen_cnt;
        e.t0    = tevt_cnt;
        sb.push_back(e);
    endtask

    // Returns at the negedge after acceptance, i.e. in the SETUP cycle.
    task automatic send(input logic [AW-1:0] a, input logic rd, input logic [IW-1:0] id,
                        input logic [31:0] wd, input int wt, input logic [31:0] sd,
                        input logic se, input logic stuck);
        arm(a, rd, id, wd, wt, sd, se, stuck);
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect();
        exp_t e;
        for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
        check("rsp_valid_wait", 64'(rsp_valid), 64'd1);
        if (sb.size() == 0) begin
            check("scoreboard_depth", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        check("rsp_read",    64'(rsp_read),    64'(e.rd));
        check("rsp_id",      64'(rsp_id),      64'(e.id));
        check("rsp_rdata",   64'(rsp_rdata),   64'(e.rdata));
        check("rsp_err",     64'(rsp_err),     64'(e.err));
        check("timeout_evt", 64'(timeout_evt), 64'(e.to));
        check("psel_in_resp",      64'(psel),      64'd0);
        check("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_valid_cleared", 64'(rsp_valid), 64'd0);
        check("psel_cycles",    64'(psel_cnt - e.p0), 64'(e.acc + 1));
        check("penable_cycles", 64'(pen_cnt - e.e0),  64'(e.acc));
        check("timeout_pulses", 64'(tevt_cnt - e.t0), 64'(e.to));
    endtask

    initial begin
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_read  = 1'b0;
        cmd_id    = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_psel",        64'(psel),        64'd0);
        check("rst_penable",     64'(penable),     64'd0);
        check("rst_pwrite",      64'(pwrite),      64'd0);
        check("rst_paddr",       64'(paddr),       64'd0);
        check("rst_pwdata",      64'(pwdata),      64'd0);
        check("rst_rsp_valid",   64'(rsp_valid),   64'd0);
        check("rst_rsp_rdata",   64'(rsp_rdata),   64'd0);
        check("rst_rsp_err",     64'(rsp_err),     64'd0);
        check("rst_rsp_id",      64'(rsp_id),      64'd0);
        check("rst_timeout_evt", 64'(timeout_evt), 64'd0);
        check("rst_cmd_ready",   64'(cmd_ready),   64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Zero-wait write; slave drives junk prdata which must not reach rsp_rdata.
        send(24'h000010, 1'b0, 4'h3, 32'h0000_1234, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("wr_setup_psel",    64'(psel),    64'd1);
        check("wr_setup_penable", 64'(penable), 64'd0);
        check("wr_pwrite",        64'(pwrite),  64'd1);
        check("wr_paddr",         64'(paddr),   64'h10);
        check("wr_pwdata",        64'(pwdata),  64'h1234);
        @(negedge clk);
        check("wr_access_penable", 64'(penable), 64'd1);
        check("wr_access_pwdata",  64'(pwdata),  64'h1234);
        @(negedge clk);
        check("wr_capture_psel",  64'(psel),      64'd0);
        check("wr_capture_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("wr_resp_at_3", 64'(rsp_valid), 64'd1);
        collect();

        // 3 wait states; pready lands on the same cycle the 4-cycle limit would fire.
        send(24'h000020, 1'b1, 4'hA, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 1'b0);
        check("rd_pwrite", 64'(pwrite), 64'd0);
        collect();

        // Undecoded address: mux answers pready=1, pslverr=1, prdata=0.
        send(24'hFFF000, 1'b1, 4'h7, 32'h0, 0, 32'h0, 1'b1, 1'b0);
        collect();

        // Write that the slave errors.
        send(24'h000044, 1'b0, 4'h2, 32'h0000_0055, 1, 32'h1111_1111, 1'b1, 1'b0);
        collect();

        // Stuck slave: abort after TO ACCESS cycles, then a normal command.
        send(24'h000080, 1'b1, 4'h9, 32'h0, 0, 32'h0000_0001, 1'b0, 1'b1);
        collect();
        send(24'h000084, 1'b1, 4'h1, 32'h0, 2, 32'h0BAD_CAFE, 1'b0, 1'b0);
        collect();

        // Response back-pressure with the next command already waiting.
        rsp_ready = 1'b0;
        send(24'h000100, 1'b1, 4'h5, 32'h0, 0, 32'h0000_AA55, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        arm(24'h000104, 1'b0, 4'h6, 32'h0000_0077, 0, 32'h3, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_id",    64'(rsp_id),    64'h5);
            check("bp_rsp_rdata", 64'(rsp_rdata), 64'hAA55);
        end
        collect();
        check("bp_next_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_next_setup_psel", 64'(psel),  64'd1);
        check("bp_next_paddr",      64'(paddr), 64'h104);
        collect();

        // Reset in the middle of ACCESS drops the bus immediately.
        send(24'h000200, 1'b1, 4'hC, 32'h0, 6, 32'h0000_0005, 1'b0, 1'b0);
        @(negedge clk);
        check("mid_access_penable", 64'(penable), 64'd1);
        resetn = 1'b0;
        #1;
        check("arst_psel",      64'(psel),      64'd0);
        check("arst_penable",   64'(penable),   64'd0);
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst_cmd_ready", 64'(cmd_ready), 64'd0);
        sb.delete();
        cfg_wait = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        send(24'h000204, 1'b0, 4'hD, 32'h0000_0099, 0, 32'h0, 1'b0, 1'b0);
        collect();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
